// File: rtl/fifo_sync_param_pkg.sv
// Shared defaults and the pointer-width helper for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer-facing signal bundle of fifo_sync_param; clk and reset stay outside.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int AW = ptr_width(DEPTH);

  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, clear, data_in,
    input  data_out, data_valid, fifo_full, fifo_empty, almost_full,
           almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, clear, data_in,
    output data_out, data_valid, fifo_full, fifo_empty, almost_full,
           almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_sync_param_ram.sv
// DEPTH x WIDTH storage: one write port and a registered read port whose output is the FIFO's data_out.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; the pointers guarantee no read before write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read and write on one edge returns the old word, which the full push+pop case relies on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, threshold flags and sticky error flags around fifo_ram.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = ptr_width(DEPTH)
) (
  input logic             clk,
  input logic             reset,
  fifo_sync_param_if.slave bus
);

  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_THRESH  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_THRESH  = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == FULL_LEVEL);
  assign empty   = (count == '0);
  assign pop_ok  = bus.pop && !empty;
  assign push_ok = bus.push && (!full || pop_ok);

  // clear wins over push/pop: nothing is accepted and no error flag is raised that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      data_valid <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (bus.push && !push_ok) overflow <= 1'b1;
      if (bus.pop && !pop_ok)   underflow <= 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok && !bus.clear),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (pop_ok && !bus.clear),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  assign bus.data_valid   = data_valid;
  assign bus.count        = count;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count >= AF_THRESH);
  assign bus.almost_empty = (count <= AE_THRESH);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule
